// File: rtl/demux_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// demux_ctrl_pkg
//   Shared definitions for the 1-to-8 demux sequencing controller.
//   - SEL_W / N_CH / DWELL_W : default geometry of the demux and dwell counter
//   - state_t                : controller state encoding (IDLE, HOLD, SCAN)
// ---------------------------------------------------------------------------
package demux_ctrl_pkg;

    localparam int SEL_W   = 3;
    localparam int N_CH    = 1 << SEL_W;
    localparam int DWELL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

endpackage

// File: rtl/demux_next_ch.sv
// ---------------------------------------------------------------------------
// demux_next_ch
//   Combinational circular search for the next enabled demux channel.
//   Starting at i_cur+1 it walks upward (modulo N_CH) and returns the first
//   channel whose mask bit is set. If i_cur is the only enabled channel the
//   search comes back around to i_cur itself.
//   Feeding i_cur = N_CH-1 yields the lowest enabled channel.
//
//   Ports:
//     i_mask  in  N_CH   channel enable mask (1 = enabled)
//     i_cur   in  SEL_W  current channel index
//     o_next  out SEL_W  next enabled channel (i_cur when mask is empty)
//     o_wrap  out 1      o_next <= i_cur, i.e. the search wrapped around
//     o_none  out 1      no channel is enabled
// ---------------------------------------------------------------------------
module demux_next_ch #(
    parameter int SEL_W = demux_ctrl_pkg::SEL_W,
    parameter int N_CH  = 1 << SEL_W
) (
    input  logic [N_CH-1:0]  i_mask,
    input  logic [SEL_W-1:0] i_cur,
    output logic [SEL_W-1:0] o_next,
    output logic             o_wrap,
    output logic             o_none
);

    logic [SEL_W-1:0] w_next;
    logic             w_found;
    int               w_idx;

    // Offsets 1..N_CH: the last offset lands back on i_cur so a
    // single enabled channel still produces a valid (wrapping) result.
    always_comb begin
        w_next  = i_cur;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = (int'(i_cur) + k) % N_CH;
            if (!w_found && i_mask[w_idx]) begin
                w_found = 1'b1;
                w_next  = SEL_W'(w_idx);
            end
        end
    end

    assign o_next = w_next;
    assign o_wrap = (w_next <= i_cur);
    assign o_none = (i_mask == '0);

endmodule

// File: rtl/demux_seq_ctrl.sv
// ---------------------------------------------------------------------------
// demux_seq_ctrl
//   Sequencer in front of a 1-to-8 demultiplexer. Drives the demux enable,
//   select and data lines in one of two modes:
//     addressed (mode=0): one request bit is routed to req_sel for dwell+1
//                         cycles, then the controller returns to IDLE.
//     scan      (mode=1): the select walks round-robin over enabled channels,
//                         each slot lasting dwell+1 cycles, and dmx_a follows
//                         scan_data with one cycle of latency.
//
//   Request handshake: a request transfers at a rising clk edge where both
//   req_valid and req_ready are high. req_ready is high only in IDLE with
//   mode=0. A transferred request whose channel is masked is discarded and
//   reported with a one-cycle req_drop pulse.
//
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     mode         0 = addressed, 1 = scan
//     ch_mask      channel enables
//     dwell        slot length minus one, sampled when a slot is loaded
//     req_valid / req_ready / req_sel / req_data   addressed request
//     scan_data    serial stream distributed in scan mode
//     dmx_en / dmx_s / dmx_a                       registered demux drive
//     busy         combinational, state != IDLE
//     frame_done   one-cycle pulse on the first cycle of a wrapped scan slot
//     req_drop     one-cycle pulse for a request to a masked channel
//     dbg_state    current FSM state encoding
// ---------------------------------------------------------------------------
module demux_seq_ctrl #(
    parameter int SEL_W   = demux_ctrl_pkg::SEL_W,
    parameter int N_CH    = 1 << SEL_W,
    parameter int DWELL_W = demux_ctrl_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic               req_data,
    input  logic               scan_data,
    output logic               dmx_en,
    output logic [SEL_W-1:0]   dmx_s,
    output logic               dmx_a,
    output logic               busy,
    output logic               frame_done,
    output logic               req_drop,
    output logic [1:0]         dbg_state
);

    import demux_ctrl_pkg::state_t;
    import demux_ctrl_pkg::IDLE;
    import demux_ctrl_pkg::HOLD;
    import demux_ctrl_pkg::SCAN;

    state_t             r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_sel;
    logic               r_a;
    logic               r_en;
    logic               r_frame_done;
    logic               r_drop;

    logic [SEL_W-1:0]   w_cur;
    logic [SEL_W-1:0]   w_next;
    logic               w_wrap;
    logic               w_none;
    logic               w_slot_end;
    logic               w_req_ok;

    // One search instance serves both uses: advancing from the current
    // channel while scanning, and finding the lowest enabled channel on
    // scan entry (search from N_CH-1 wraps to index 0 first).
    assign w_cur = (r_state == SCAN) ? r_sel : SEL_W'(N_CH - 1);

    demux_next_ch #(
        .SEL_W (SEL_W),
        .N_CH  (N_CH)
    ) u_next_ch (
        .i_mask (ch_mask),
        .i_cur  (w_cur),
        .o_next (w_next),
        .o_wrap (w_wrap),
        .o_none (w_none)
    );

    assign w_req_ok   = ch_mask[req_sel];
    assign w_slot_end = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_a          <= 1'b0;
            r_en         <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_en <= 1'b0;
                    if (!mode) begin
                        if (req_valid) begin
                            if (w_req_ok) begin
                                r_state <= HOLD;
                                r_cnt   <= dwell;
                                r_sel   <= req_sel;
                                r_a     <= req_data;
                                r_en    <= 1'b1;
                            end else begin
                                r_drop  <= 1'b1;
                            end
                        end
                    end else if (!w_none) begin
                        // Scan entry never raises frame_done.
                        r_state <= SCAN;
                        r_cnt   <= dwell;
                        r_sel   <= w_next;
                        r_a     <= scan_data;
                        r_en    <= 1'b1;
                    end
                end

                HOLD: begin
                    // Counter reaches 0 after dwell cycles; leaving on that
                    // edge gives dwell+1 enabled cycles in total.
                    if (w_slot_end) begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end

                SCAN: begin
                    r_a <= scan_data;
                    if (w_slot_end) begin
                        // mode and ch_mask only matter here, at slot end.
                        if (!mode || w_none) begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                        end else begin
                            r_sel        <= w_next;
                            r_cnt        <= dwell;
                            r_frame_done <= w_wrap;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign dmx_en     = r_en;
    assign dmx_s      = r_sel;
    assign dmx_a      = r_a;
    assign frame_done = r_frame_done;
    assign req_drop   = r_drop;
    assign req_ready  = (r_state == IDLE) && !mode;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule
